// File: rtl/prco_decoder_pipe.sv
// prco_decoder_pipe
//   Handshaked PRCO instruction decoder placed between fetch and the
//   execute/ALU/RAM stage. It accepts one instruction per cycle and
//   presents a registered decoded bundle one cycle later. A one-entry skid
//   register absorbs the instruction accepted while the output is stalled.
//   NOPs are accepted and dropped. An illegal opcode is dropped and raises
//   a sticky halt that blocks further input until reset.
//
// Opcode map (opcode = instr[INSTR_W-1 -: OP_W]):
//   0 NOP, 1 MOV, 2 MOVI, 3 ADD, 4 ADDI, 5 SUBI, 6 CMP, 7 JMP,
//   8 LW, 9 SW, 10 WRITE. Any other value is illegal.
//
// Ports:
//   i_clk, i_reset         clock, synchronous active-high reset
//   i_valid/q_ready        instruction handshake from fetch (i_instr)
//   i_flush                drop the output and skid contents
//   q_valid/i_ready        decoded bundle handshake to downstream
//   q_op .. q_simm         decoded fields
//   q_reg_we .. q_new_uart1_data  dependency flags
//   q_halt                 sticky illegal-opcode halt
//   q_decoded_count        bundles handed downstream (wraps)
module prco_decoder_pipe #(
    parameter int INSTR_W     = 16,
    parameter int OP_W        = 5,
    parameter int RS_W        = 3,
    parameter int IMM_W       = 8,
    parameter int SIMM_W      = 5,
    parameter int THREE_OP_EN = 0,
    parameter int CNT_W       = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_valid,
    output logic               q_ready,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic               i_flush,
    output logic               q_valid,
    input  logic               i_ready,
    output logic [OP_W-1:0]    q_op,
    output logic [RS_W-1:0]    q_seld,
    output logic [RS_W-1:0]    q_sela,
    output logic [RS_W-1:0]    q_selb,
    output logic               q_third_sel,
    output logic [IMM_W-1:0]   q_imm,
    output logic [SIMM_W-1:0]  q_simm,
    output logic               q_reg_we,
    output logic               q_req_alu,
    output logic               q_req_ram,
    output logic               q_req_ram_we,
    output logic               q_new_uart1_data,
    output logic               q_halt,
    output logic [CNT_W-1:0]   q_decoded_count
);

    localparam logic [OP_W-1:0] OP_NOP   = OP_W'(0);
    localparam logic [OP_W-1:0] OP_MOV   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_MOVI  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_SUBI  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_CMP   = OP_W'(6);
    localparam logic [OP_W-1:0] OP_JMP   = OP_W'(7);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(8);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(9);
    localparam logic [OP_W-1:0] OP_WRITE = OP_W'(10);

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [RS_W-1:0]   seld;
        logic [RS_W-1:0]   sela;
        logic [RS_W-1:0]   selb;
        logic              third_sel;
        logic [IMM_W-1:0]  imm;
        logic [SIMM_W-1:0] simm;
        logic              reg_we;
        logic              req_alu;
        logic              req_ram;
        logic              req_ram_we;
        logic              new_uart1_data;
    } bundle_t;

    bundle_t             dec_bundle;
    logic                dec_nop;
    logic                dec_legal;

    bundle_t             out_reg, out_next;
    bundle_t             skid_reg, skid_next;
    logic                out_valid_reg, out_valid_next;
    logic                skid_valid_reg, skid_valid_next;
    logic                ready_reg, ready_next;
    logic                halt_reg, halt_next;
    logic [CNT_W-1:0]    count_reg, count_next;

    logic                out_fire;
    logic                in_acc;
    logic                in_live;

    // Field extraction is unconditional; only the flags depend on the opcode.
    always_comb begin
        dec_bundle      = '0;
        dec_bundle.op   = i_instr[INSTR_W-1 -: OP_W];
        dec_bundle.seld = i_instr[INSTR_W-OP_W-1 -: RS_W];
        dec_bundle.sela = i_instr[INSTR_W-OP_W-RS_W-1 -: RS_W];
        dec_bundle.selb = i_instr[INSTR_W-OP_W-2*RS_W-1 -: RS_W];
        dec_bundle.imm  = i_instr[IMM_W-1:0];
        dec_bundle.simm = i_instr[SIMM_W-1:0];
        dec_nop   = 1'b0;
        dec_legal = 1'b1;
        case (dec_bundle.op)
            OP_NOP: dec_nop = 1'b1;
            OP_MOV, OP_MOVI, OP_ADDI, OP_SUBI: begin
                dec_bundle.reg_we  = 1'b1;
                dec_bundle.req_alu = 1'b1;
            end
            OP_ADD: begin
                dec_bundle.reg_we    = 1'b1;
                dec_bundle.req_alu   = 1'b1;
                dec_bundle.third_sel = (THREE_OP_EN != 0);
            end
            OP_LW: begin
                dec_bundle.reg_we  = 1'b1;
                dec_bundle.req_ram = 1'b1;
            end
            OP_SW: begin
                dec_bundle.req_ram    = 1'b1;
                dec_bundle.req_ram_we = 1'b1;
            end
            OP_CMP:   dec_bundle.req_alu        = 1'b1;
            OP_JMP:   dec_bundle.reg_we         = 1'b1;
            OP_WRITE: dec_bundle.new_uart1_data = 1'b1;
            default:  dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        out_fire = out_valid_reg & i_ready;
        in_acc   = i_valid & ready_reg;
        in_live  = in_acc & dec_legal & ~dec_nop;

        out_next        = out_reg;
        skid_next       = skid_reg;
        out_valid_next  = out_valid_reg;
        skid_valid_next = skid_valid_reg;
        halt_next       = halt_reg;
        // A transfer that completes in a flush cycle was seen downstream,
        // so it is still counted.
        count_next      = count_reg + CNT_W'(out_fire);

        if (i_flush) begin
            out_valid_next  = 1'b0;
            skid_valid_next = 1'b0;
        end else begin
            if (in_acc && !dec_legal) begin
                halt_next = 1'b1;
            end
            if (!out_valid_reg || out_fire) begin
                // Output slot frees this edge: the older skid entry has
                // precedence, otherwise the new instruction goes straight in.
                if (skid_valid_reg) begin
                    out_next        = skid_reg;
                    out_valid_next  = 1'b1;
                    skid_valid_next = in_live;
                    if (in_live) begin
                        skid_next = dec_bundle;
                    end
                end else begin
                    out_valid_next = in_live;
                    if (in_live) begin
                        out_next = dec_bundle;
                    end
                end
            end else if (in_live) begin
                // ready_reg guarantees the skid slot is empty here.
                skid_next       = dec_bundle;
                skid_valid_next = 1'b1;
            end
        end

        // Registered ready: computed from next-state occupancy so an accept
        // can never overflow the skid slot.
        ready_next = ~skid_valid_next & ~halt_next;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            out_reg        <= '0;
            skid_reg       <= '0;
            out_valid_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
            ready_reg      <= 1'b0;
            halt_reg       <= 1'b0;
            count_reg      <= '0;
        end else begin
            out_reg        <= out_next;
            skid_reg       <= skid_next;
            out_valid_reg  <= out_valid_next;
            skid_valid_reg <= skid_valid_next;
            ready_reg      <= ready_next;
            halt_reg       <= halt_next;
            count_reg      <= count_next;
        end
    end

    assign q_ready          = ready_reg;
    assign q_valid          = out_valid_reg;
    assign q_op             = out_reg.op;
    assign q_seld           = out_reg.seld;
    assign q_sela           = out_reg.sela;
    assign q_selb           = out_reg.selb;
    assign q_third_sel      = out_reg.third_sel;
    assign q_imm            = out_reg.imm;
    assign q_simm           = out_reg.simm;
    assign q_reg_we         = out_reg.reg_we;
    assign q_req_alu        = out_reg.req_alu;
    assign q_req_ram        = out_reg.req_ram;
    assign q_req_ram_we     = out_reg.req_ram_we;
    assign q_new_uart1_data = out_reg.new_uart1_data;
    assign q_halt           = halt_reg;
    assign q_decoded_count  = count_reg;

endmodule

// File: tb/tb_prco_decoder_pipe.sv
module tb_prco_decoder_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic [15:0] i_instr;
    logic        i_flush;
    logic        i_ready;

    logic        q_ready_a, q_valid_a, q_third_a, q_we_a, q_alu_a, q_ram_a, q_ramwe_a, q_uart_a, q_halt_a;
    logic [4:0]  q_op_a, q_simm_a;
    logic [2:0]  q_seld_a, q_sela_a, q_selb_a;
    logic [7:0]  q_imm_a;
    logic [15:0] q_cnt_a;

    logic        q_ready_b, q_valid_b, q_third_b, q_we_b, q_alu_b, q_ram_b, q_ramwe_b, q_uart_b, q_halt_b;
    logic [4:0]  q_op_b, q_simm_b;
    logic [2:0]  q_seld_b, q_sela_b, q_selb_b;
    logic [7:0]  q_imm_b;
    logic [1:0]  q_cnt_b;

    always #5 clk = ~clk;

    // Instance A: three-operand ADD, 16-bit counter.
    prco_decoder_pipe #(.THREE_OP_EN(1), .CNT_W(16)) dut_a (
        .i_clk(clk), .i_reset(rst), .i_valid(i_valid), .q_ready(q_ready_a),
        .i_instr(i_instr), .i_flush(i_flush), .q_valid(q_valid_a), .i_ready(i_ready),
        .q_op(q_op_a), .q_seld(q_seld_a), .q_sela(q_sela_a), .q_selb(q_selb_a),
        .q_third_sel(q_third_a), .q_imm(q_imm_a), .q_simm(q_simm_a),
        .q_reg_we(q_we_a), .q_req_alu(q_alu_a), .q_req_ram(q_ram_a),
        .q_req_ram_we(q_ramwe_a), .q_new_uart1_data(q_uart_a),
        .q_halt(q_halt_a), .q_decoded_count(q_cnt_a)
    );

    // Instance B: two-operand ADD, 2-bit wrapping counter, same stimulus.
    prco_decoder_pipe #(.THREE_OP_EN(0), .CNT_W(2)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_valid(i_valid), .q_ready(q_ready_b),
        .i_instr(i_instr), .i_flush(i_flush), .q_valid(q_valid_b), .i_ready(i_ready),
        .q_op(q_op_b), .q_seld(q_seld_b), .q_sela(q_sela_b), .q_selb(q_selb_b),
        .q_third_sel(q_third_b), .q_imm(q_imm_b), .q_simm(q_simm_b),
        .q_reg_we(q_we_b), .q_req_alu(q_alu_b), .q_req_ram(q_ram_b),
        .q_req_ram_we(q_ramwe_b), .q_new_uart1_data(q_uart_b),
        .q_halt(q_halt_b), .q_decoded_count(q_cnt_b)
    );

    // flg = {reg_we, req_alu, req_ram, req_ram_we, new_uart1_data}
    typedef struct packed {
        logic [15:0] instr;
        logic        live;
        logic [4:0]  flg;
        logic        third;
    } vec_t;

    vec_t tbl [12];
    vec_t ill_vec;
    vec_t src_q [$];
    vec_t exp_q [$];
    int   exp_cnt;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pack_exp(input vec_t v, input logic third);
        return 64'({v.instr[15:11], v.instr[10:8], v.instr[7:5], v.instr[4:2], third,
                    v.instr[7:0], v.instr[4:0], v.flg});
    endfunction

    function automatic logic [63:0] pack_a();
        return 64'({q_op_a, q_seld_a, q_sela_a, q_selb_a, q_third_a, q_imm_a, q_simm_a,
                    q_we_a, q_alu_a, q_ram_a, q_ramwe_a, q_uart_a});
    endfunction

    function automatic logic [63:0] pack_b();
        return 64'({q_op_b, q_seld_b, q_sela_b, q_selb_b, q_third_b, q_imm_b, q_simm_b,
                    q_we_b, q_alu_b, q_ram_b, q_ramwe_b, q_uart_b});
    endfunction

    // One clock cycle, entered and left just after a falling edge.
    task automatic cycle(input logic rdy, input logic flush);
        vec_t v;
        logic acc, fire;
        i_ready = rdy;
        i_flush = flush;
        i_valid = (src_q.size() != 0);
        i_instr = i_valid ? src_q[0].instr : 16'h0000;
        fire = q_valid_a && rdy;
        acc  = i_valid && q_ready_a;
        check("count_a", 64'(q_cnt_a), 64'(exp_cnt % 65536));
        check("count_b", 64'(q_cnt_b), 64'(exp_cnt % 4));
        if (fire) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_output: got op 0x%0h, expected no bundle", q_op_a);
            end else begin
                v = exp_q.pop_front();
                check("bundle_a", pack_a(), pack_exp(v, v.third));
                check("bundle_b", pack_b(), pack_exp(v, 1'b0));
            end
            exp_cnt++;
        end
        if (acc) begin
            v = src_q.pop_front();
            $display("[TB] accept instr 0x%04h%s", v.instr, flush ? " (flushed)" : "");
            if (!flush && v.live) exp_q.push_back(v);
        end
        if (flush) exp_q.delete();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input string name, input bit rand_rdy);
        for (int k = 0; k < 300 && (src_q.size() != 0 || exp_q.size() != 0); k++)
            cycle(rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
        check(name, 64'(src_q.size() + exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_valid = 1'b0;
        i_flush = 1'b0;
        i_ready = 1'b0;
        i_instr = 16'h0000;
        src_q.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        check("rst_valid", 64'(q_valid_a), 64'd0);
        check("rst_halt", 64'(q_halt_a), 64'd0);
        check("rst_count_a", 64'(q_cnt_a), 64'd0);
        check("rst_count_b", 64'(q_cnt_b), 64'd0);
        check("rst_flags", pack_a() & 64'h1F, 64'd0);
        exp_cnt = 0;
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 64'(q_ready_a), 64'd1);
    endtask

    int c0;
    int seq [5];

    initial begin
        tbl[0]  = '{instr: 16'h125A, live: 1'b1, flg: 5'b11000, third: 1'b0}; // MOVI d2 0x5A
        tbl[1]  = '{instr: 16'h0B80, live: 1'b1, flg: 5'b11000, third: 1'b0}; // MOV
        tbl[2]  = '{instr: 16'h194C, live: 1'b1, flg: 5'b11000, third: 1'b1}; // ADD d1 a2 b3
        tbl[3]  = '{instr: 16'h2555, live: 1'b1, flg: 5'b11000, third: 1'b0}; // ADDI
        tbl[4]  = '{instr: 16'h2ABC, live: 1'b1, flg: 5'b11000, third: 1'b0}; // SUBI
        tbl[5]  = '{instr: 16'h3123, live: 1'b1, flg: 5'b01000, third: 1'b0}; // CMP
        tbl[6]  = '{instr: 16'h3F0F, live: 1'b1, flg: 5'b10000, third: 1'b0}; // JMP
        tbl[7]  = '{instr: 16'h4321, live: 1'b1, flg: 5'b10100, third: 1'b0}; // LW
        tbl[8]  = '{instr: 16'h4ABC, live: 1'b1, flg: 5'b00110, third: 1'b0}; // SW
        tbl[9]  = '{instr: 16'h5077, live: 1'b1, flg: 5'b00001, third: 1'b0}; // WRITE
        tbl[10] = '{instr: 16'h0000, live: 1'b0, flg: 5'b00000, third: 1'b0}; // NOP
        tbl[11] = '{instr: 16'h07FF, live: 1'b0, flg: 5'b00000, third: 1'b0}; // NOP, fields set
        ill_vec = '{instr: 16'h5800, live: 1'b0, flg: 5'b00000, third: 1'b0}; // opcode 11
        seq = '{1, 2, 3, 0, 1};

        do_reset();

        // Single MOVI: visible one cycle after acceptance.
        src_q.push_back(tbl[0]);
        cycle(1'b1, 1'b0);
        check("movi_latency", 64'(q_valid_a), 64'd1);
        check("movi_fields", pack_a(), pack_exp(tbl[0], 1'b0));
        cycle(1'b1, 1'b0);
        check("movi_count", 64'(q_cnt_a), 64'd1);

        // Whole opcode table streamed with random downstream stalls.
        for (int i = 0; i < 12; i++) src_q.push_back(tbl[i]);
        drain("table_drain", 1'b1);
        cycle(1'b1, 1'b0);
        check("table_idle", 64'(q_valid_a), 64'd0);

        // LW, SW, WRITE against a stalled sink: third is held at the source.
        c0 = exp_cnt;
        src_q.push_back(tbl[7]);
        src_q.push_back(tbl[8]);
        src_q.push_back(tbl[9]);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        check("bp_ready_low", 64'(q_ready_a), 64'd0);
        cycle(1'b0, 1'b0);
        check("bp_held_src", 64'(src_q.size()), 64'd1);
        check("bp_ready_still_low", 64'(q_ready_a), 64'd0);
        drain("bp_drain", 1'b0);
        check("bp_count", 64'(exp_cnt - c0), 64'd3);

        // NOP is squashed, only ADD is emitted.
        c0 = exp_cnt;
        src_q.push_back(tbl[10]);
        src_q.push_back(tbl[2]);
        drain("nop_add_drain", 1'b0);
        cycle(1'b1, 1'b0);
        check("nop_add_count", 64'(q_cnt_a), 64'(c0 + 1));

        // Flush with output and skid both full.
        src_q.push_back(tbl[2]);
        src_q.push_back(tbl[7]);
        src_q.push_back(tbl[5]);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        check("fl_full_ready", 64'(q_ready_a), 64'd0);
        c0 = exp_cnt;
        cycle(1'b0, 1'b1);
        check("fl_valid", 64'(q_valid_a), 64'd0);
        check("fl_ready", 64'(q_ready_a), 64'd1);
        check("fl_count", 64'(q_cnt_a), 64'(c0));
        // Flush while an instruction is accepted: it is discarded too.
        cycle(1'b0, 1'b0);
        src_q.push_back(tbl[6]);
        cycle(1'b0, 1'b1);
        check("fl_in_valid", 64'(q_valid_a), 64'd0);
        check("fl_in_src", 64'(src_q.size()), 64'd0);

        // Illegal opcode behind a pending bundle.
        src_q.push_back(tbl[0]);
        src_q.push_back(ill_vec);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        check("ill_halt", 64'(q_halt_a), 64'd1);
        check("ill_ready", 64'(q_ready_a), 64'd0);
        check("ill_pending", 64'(q_valid_a), 64'd1);
        src_q.push_back(tbl[1]);
        repeat (2) cycle(1'b0, 1'b0);
        repeat (4) cycle(1'b1, 1'b0);
        check("ill_drained", 64'(exp_q.size()), 64'd0);
        check("ill_idle", 64'(q_valid_a), 64'd0);
        check("ill_ignored", 64'(src_q.size()), 64'd1);
        cycle(1'b1, 1'b1);
        check("ill_flush_keeps_halt", 64'(q_halt_a), 64'd1);
        check("ill_flush_ready", 64'(q_ready_a), 64'd0);

        // Reset mid-stream clears halt and everything held.
        do_reset();

        // Counter wrap on the 2-bit instance: 1,2,3,0,1.
        for (int j = 0; j < 5; j++) begin
            src_q.push_back(tbl[j + 1]);
            for (int k = 0; k < 20 && exp_cnt != j + 1; k++) cycle(1'b1, 1'b0);
            check("cnt_w2_seq", 64'(q_cnt_b), 64'(seq[j]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
